// File: rtl/tcb_rmw_man_if.sv
// TCB bus interface; clock and reset travel with the bus.
// Modports: man (initiator side) and sub (subordinate side).
interface tcb_if #(
    parameter int unsigned AW  = 32,
    parameter int unsigned DW  = 32,
    parameter int unsigned DLY = 1
) (
    input logic clk,
    input logic rst
);

    logic          vld;
    logic          wen;
    logic [AW-1:0] adr;
    logic [DW-1:0] wdt;
    logic          rdy;
    logic [DW-1:0] rdt;
    logic          err;

    modport man (
        input  clk, rst,
        output vld, wen, adr, wdt,
        input  rdy, rdt, err
    );

    modport sub (
        input  clk, rst,
        input  vld, wen, adr, wdt,
        output rdy, rdt, err
    );

endinterface

// File: rtl/tcb_rmw_man.sv
// TCB manager executing atomic read-modify-write (set/clear/toggle) commands.
// Optional macro TCB_RMW_SKIP_EN: skip the write when the value is unchanged.
module tcb_rmw_man #(
    parameter int unsigned AW  = 32,
    parameter int unsigned DW  = 32,
    parameter int unsigned DLY = 1
) (
    tcb_if.man              tcb,
    input  logic            cmd_vld,
    output logic            cmd_rdy,
    input  logic [AW-1:0]   cmd_adr,
    input  logic [DW-1:0]   cmd_set,
    input  logic [DW-1:0]   cmd_clr,
    input  logic [DW-1:0]   cmd_tgl,
    output logic            sts_vld,
    output logic [DW-1:0]   sts_rdt,
    output logic            sts_err
);

    localparam int unsigned CW       = (DLY > 1) ? $clog2(DLY) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DLY - 1);
    localparam bit          ZERO_DLY = (DLY == 0);

    // Bus parameters must agree with the interface instance
    generate
        if ((AW != tcb.AW) || (DW != tcb.DW) || (DLY != tcb.DLY)) begin : g_param_chk
            $error("tcb_rmw_man: AW/DW/DLY do not match the tcb interface");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_REQ,
        S_WR_WAIT,
        S_DONE
    } state_e;

    state_e        state_q, state_d, rd_next_c;
    logic [AW-1:0] adr_q, adr_d;
    logic [DW-1:0] set_q, set_d;
    logic [DW-1:0] clr_q, clr_d;
    logic [DW-1:0] tgl_q, tgl_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          vld_q, vld_d;
    logic          wen_q, wen_d;
    logic [DW-1:0] wdt_q, wdt_d;
    logic          sts_vld_q, sts_vld_d;
    logic [DW-1:0] sts_rdt_q, sts_rdt_d;
    logic          sts_err_q, sts_err_d;

    logic          xfer_c;
    logic          cnt_last_c;
    logic          rd_smp_c;
    logic          wr_smp_c;
    logic [DW-1:0] new_c;
    logic          skip_c;

    assign xfer_c     = tcb.vld & tcb.rdy;
    assign cnt_last_c = (cnt_q == CNT_LAST);
    assign rd_smp_c   = ((state_q == S_RD_REQ) && xfer_c && ZERO_DLY) ||
                        ((state_q == S_RD_WAIT) && cnt_last_c);
    assign wr_smp_c   = ((state_q == S_WR_REQ) && xfer_c && ZERO_DLY) ||
                        ((state_q == S_WR_WAIT) && cnt_last_c);
    assign new_c      = ((tcb.rdt & ~clr_q) | set_q) ^ tgl_q;

`ifdef TCB_RMW_SKIP_EN
    assign skip_c = (new_c == tcb.rdt);
`else
    assign skip_c = 1'b0;
`endif

    // Where the read sample leads: error or unchanged value ends the command
    assign rd_next_c = (tcb.err || skip_c) ? S_DONE : S_WR_REQ;

    // State register
    always_ff @(posedge tcb.clk or posedge tcb.rst) begin
        if (tcb.rst) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (cmd_vld)    state_d = S_RD_REQ;
            S_RD_REQ:  if (xfer_c)     state_d = ZERO_DLY ? rd_next_c : S_RD_WAIT;
            S_RD_WAIT: if (cnt_last_c) state_d = rd_next_c;
            S_WR_REQ:  if (xfer_c)     state_d = ZERO_DLY ? S_DONE : S_WR_WAIT;
            S_WR_WAIT: if (cnt_last_c) state_d = S_DONE;
            S_DONE:                    state_d = S_IDLE;
            default:                   state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values; bus outputs follow the next state
    always_comb begin
        adr_d     = adr_q;
        set_d     = set_q;
        clr_d     = clr_q;
        tgl_d     = tgl_q;
        cnt_d     = '0;
        wdt_d     = wdt_q;
        sts_rdt_d = sts_rdt_q;
        sts_err_d = sts_err_q;
        vld_d     = (state_d == S_RD_REQ) || (state_d == S_WR_REQ);
        wen_d     = (state_d == S_WR_REQ);
        sts_vld_d = (state_d == S_DONE);
        if ((state_q == S_IDLE) && cmd_vld) begin
            adr_d = cmd_adr;
            set_d = cmd_set;
            clr_d = cmd_clr;
            tgl_d = cmd_tgl;
        end
        if (((state_q == S_RD_WAIT) || (state_q == S_WR_WAIT)) && !cnt_last_c) begin
            cnt_d = cnt_q + CW'(1);
        end
        if (rd_smp_c) begin
            sts_rdt_d = tcb.rdt;
            sts_err_d = tcb.err;
            wdt_d     = new_c;
        end
        if (wr_smp_c) begin
            sts_err_d = tcb.err;
        end
    end

    // Datapath and output registers
    always_ff @(posedge tcb.clk or posedge tcb.rst) begin
        if (tcb.rst) begin
            adr_q     <= '0;
            set_q     <= '0;
            clr_q     <= '0;
            tgl_q     <= '0;
            cnt_q     <= '0;
            vld_q     <= 1'b0;
            wen_q     <= 1'b0;
            wdt_q     <= '0;
            sts_vld_q <= 1'b0;
            sts_rdt_q <= '0;
            sts_err_q <= 1'b0;
        end else begin
            adr_q     <= adr_d;
            set_q     <= set_d;
            clr_q     <= clr_d;
            tgl_q     <= tgl_d;
            cnt_q     <= cnt_d;
            vld_q     <= vld_d;
            wen_q     <= wen_d;
            wdt_q     <= wdt_d;
            sts_vld_q <= sts_vld_d;
            sts_rdt_q <= sts_rdt_d;
            sts_err_q <= sts_err_d;
        end
    end

    assign cmd_rdy = (state_q == S_IDLE);
    assign tcb.vld = vld_q;
    assign tcb.wen = wen_q;
    assign tcb.adr = adr_q;
    assign tcb.wdt = wdt_q;
    assign sts_vld = sts_vld_q;
    assign sts_rdt = sts_rdt_q;
    assign sts_err = sts_err_q;

endmodule

// File: tb/tb_tcb_rmw_man.sv
// Scoreboard bench for tcb_rmw_man with a behavioural TCB memory subordinate.
// Honours TCB_RMW_SKIP_EN in its reference model.
module tb_tcb_rmw_man;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned DLY = 1;
`ifdef TCB_RMW_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    typedef struct {
        logic [DW-1:0] rdt;
        logic          err;
        int unsigned   lat;
    } sts_t;

    typedef struct {
        logic [AW-1:0] adr;
        logic [DW-1:0] wdt;
    } wr_t;

    logic          clk;
    logic          rst;
    logic          cmd_vld;
    logic          cmd_rdy;
    logic [AW-1:0] cmd_adr;
    logic [DW-1:0] cmd_set;
    logic [DW-1:0] cmd_clr;
    logic [DW-1:0] cmd_tgl;
    logic          sts_vld;
    logic [DW-1:0] sts_rdt;
    logic          sts_err;

    sts_t          exp_sts[$];
    wr_t           exp_wr[$];
    logic [DW-1:0] model_mem [16];
    logic [DW-1:0] sub_mem [16];
    logic [AW-1:0] cur_adr;
    int unsigned   stall_rd;
    int unsigned   stall_wr;
    int unsigned   cyc;
    int unsigned   acc_cyc;
    int            checks;
    int            errors;

    tcb_if #(.AW(AW), .DW(DW), .DLY(DLY)) tcb (.clk(clk), .rst(rst));

    tcb_rmw_man #(.AW(AW), .DW(DW), .DLY(DLY)) dut (
        .tcb     (tcb),
        .cmd_vld (cmd_vld),
        .cmd_rdy (cmd_rdy),
        .cmd_adr (cmd_adr),
        .cmd_set (cmd_set),
        .cmd_clr (cmd_clr),
        .cmd_tgl (cmd_tgl),
        .sts_vld (sts_vld),
        .sts_rdt (sts_rdt),
        .sts_err (sts_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input int i);
        if (i == 0)      return 32'h0000_00F0;
        else if (i == 1) return 32'h0000_0005;
        else             return 32'h1234_5678 ^ (32'(i) * 32'h0101_0101);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h cycle=%0d", nm, act, exp, cyc);
        end
    endtask

    // Subordinate: memory response one cycle after the transfer; nibble E -> read err, D -> write err
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) sub_mem[i] <= init_val(i);
            tcb.rdt <= '0;
            tcb.err <= 1'b0;
        end else if (tcb.vld && tcb.rdy) begin
            if (!tcb.wen) begin
                tcb.rdt <= sub_mem[tcb.adr[3:0]];
                tcb.err <= (tcb.adr[7:4] == 4'hE);
            end else begin
                tcb.err <= (tcb.adr[7:4] == 4'hD);
                if (tcb.adr[7:4] != 4'hD) sub_mem[tcb.adr[3:0]] <= tcb.wdt;
            end
        end
    end

    // Monitor: drives rdy stalls, checks bus requests, status and latency against the queues
    always @(negedge clk) begin
        static int unsigned stall_cnt = 0;
        static logic        prev_hold = 1'b0;
        static logic        prev_wen  = 1'b0;
        sts_t e;
        wr_t  w;
        cyc++;
        if (rst) begin
            chk("rst_vld",     64'(tcb.vld), 64'd0);
            chk("rst_wen",     64'(tcb.wen), 64'd0);
            chk("rst_adr",     64'(tcb.adr), 64'd0);
            chk("rst_wdt",     64'(tcb.wdt), 64'd0);
            chk("rst_cmd_rdy", 64'(cmd_rdy), 64'd1);
            chk("rst_sts_vld", 64'(sts_vld), 64'd0);
            chk("rst_sts_rdt", 64'(sts_rdt), 64'd0);
            chk("rst_sts_err", 64'(sts_err), 64'd0);
            exp_sts.delete();
            exp_wr.delete();
            tcb.rdy   = 1'b0;
            stall_cnt = 0;
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("vld_held", 64'(tcb.vld), 64'd1);
                chk("wen_held", 64'(tcb.wen), 64'(prev_wen));
            end
            if (tcb.vld) begin
                chk("bus_adr", 64'(tcb.adr), 64'(cur_adr));
                if (tcb.wen) begin
                    if (exp_wr.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write adr=0x%0h wdt=0x%0h cycle=%0d", tcb.adr, tcb.wdt, cyc);
                    end else begin
                        chk("bus_wdt", 64'(tcb.wdt), 64'(exp_wr[0].wdt));
                    end
                end
                if (stall_cnt < (tcb.wen ? stall_wr : stall_rd)) begin
                    tcb.rdy = 1'b0;
                    stall_cnt++;
                end else begin
                    tcb.rdy = 1'b1;
                end
            end else begin
                tcb.rdy   = 1'b0;
                stall_cnt = 0;
            end
            if (tcb.vld && tcb.rdy && tcb.wen && exp_wr.size() != 0) begin
                w = exp_wr.pop_front();
                chk("wr_adr", 64'(tcb.adr), 64'(w.adr));
            end
            prev_hold = tcb.vld && !tcb.rdy;
            prev_wen  = tcb.wen;
            if (cmd_vld && cmd_rdy) acc_cyc = cyc;
            if (sts_vld) begin
                if (exp_sts.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_sts rdt=0x%0h err=%0d cycle=%0d", sts_rdt, sts_err, cyc);
                end else begin
                    e = exp_sts.pop_front();
                    chk("sts_rdt", 64'(sts_rdt), 64'(e.rdt));
                    chk("sts_err", 64'(sts_err), 64'(e.err));
                    chk("sts_lat", 64'(cyc - acc_cyc), 64'(e.lat));
                end
            end else if (exp_sts.size() != 0 && (cyc - acc_cyc) > 200) begin
                checks++;
                errors++;
                $display("FAIL sts_timeout pending=%0d cycle=%0d", exp_sts.size(), cyc);
                exp_sts.delete();
            end
        end
    end

    task automatic wait_idle();
        int budget = 0;
        while (!cmd_rdy) begin
            @(posedge clk);
            #1;
            budget++;
            if (budget > 500) begin
                $display("FAIL idle_timeout cmd_rdy=%0d required=1", cmd_rdy);
                $fatal(1);
            end
        end
    endtask

    // Compute the expected outcome from the RMW rules, queue it, then present the command
    task automatic issue(input logic [AW-1:0] a, input logic [DW-1:0] s, input logic [DW-1:0] c,
                         input logic [DW-1:0] t, input int unsigned srd, input int unsigned swr);
        logic [DW-1:0] old_v;
        logic [DW-1:0] new_v;
        logic          rerr;
        logic          werr;
        logic          do_wr;
        sts_t          e;
        wait_idle();
        old_v = model_mem[a[3:0]];
        new_v = ((old_v & ~c) | s) ^ t;
        rerr  = (a[7:4] == 4'hE);
        werr  = (a[7:4] == 4'hD);
        do_wr = !rerr && !(SKIP && (new_v == old_v));
        e.rdt = old_v;
        e.err = rerr || (do_wr && werr);
        e.lat = do_wr ? (3 + 2 * DLY + srd + swr) : (2 + DLY + srd);
        if (do_wr) begin
            exp_wr.push_back('{adr: a, wdt: new_v});
            if (!werr) model_mem[a[3:0]] = new_v;
        end
        exp_sts.push_back(e);
        stall_rd = srd;
        stall_wr = swr;
        cur_adr  = a;
        cmd_adr  = a;
        cmd_set  = s;
        cmd_clr  = c;
        cmd_tgl  = t;
        cmd_vld  = 1'b1;
        @(posedge clk);
        #1;
        cmd_vld  = 1'b0;
        cmd_adr  = AW'($urandom());
        cmd_set  = DW'($urandom());
        cmd_clr  = DW'($urandom());
        cmd_tgl  = DW'($urandom());
    endtask

    task automatic hold_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) model_mem[i] = init_val(i);
        stall_rd = 0;
        stall_wr = 0;
    endtask

    initial begin
        logic [3:0]    nib;
        int unsigned   pick;
        logic [AW-1:0] a;
        int            budget;
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        acc_cyc  = 0;
        cur_adr  = '0;
        stall_rd = 0;
        stall_wr = 0;
        cmd_vld  = 1'b0;
        cmd_adr  = '0;
        cmd_set  = '0;
        cmd_clr  = '0;
        cmd_tgl  = '0;
        for (int i = 0; i < 16; i++) model_mem[i] = init_val(i);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed: basic RMW, stalled RMW, read error, unchanged value
        issue(32'h0000_0000, 32'h1, 32'h10, 32'h100, 0, 0);
        issue(32'h0000_0002, 32'h0F00_0000, 32'h0000_00FF, 32'h8000_0001, 3, 2);
        issue(32'h0000_00E0, 32'hFFFF_FFFF, 32'h0, 32'h0, 0, 0);
        issue(32'h0000_0001, 32'h4, 32'h0, 32'h0, 0, 0);
        issue(32'h0000_00D3, 32'h3, 32'h0, 32'h0, 1, 1);

        // Reset in the cycle after the read transfer
        issue(32'h0000_0003, 32'hA, 32'h0, 32'h0, 0, 0);
        @(posedge clk);
        #1;
        hold_reset();
        // Reset while the read request is stalled on the bus
        issue(32'h0000_0004, 32'h1, 32'h0, 32'h0, 3, 0);
        hold_reset();
        // Normal command after reset
        issue(32'h0000_0000, 32'h1, 32'h10, 32'h100, 0, 0);

        // Randomised commands
        for (int n = 0; n < 60; n++) begin
            pick = $urandom_range(0, 7);
            nib  = (pick == 6) ? 4'hE : (pick == 7) ? 4'hD : 4'(pick);
            a    = (AW'($urandom()) & 32'hFFFF_FF0F) | {24'h0, nib, 4'h0};
            if ($urandom_range(0, 3) == 0)
                issue(a, DW'($urandom()) & 32'h0000_0003, 32'h0, 32'h0, $urandom_range(0, 3), $urandom_range(0, 3));
            else
                issue(a, DW'($urandom()), DW'($urandom()), DW'($urandom()), $urandom_range(0, 3), $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        budget = 0;
        while (exp_sts.size() != 0 && budget < 300) begin
            @(posedge clk);
            budget++;
        end
        repeat (4) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
